// File: rtl/lbp_pkg.sv
// Shared constants for the LBP histogram block: bin geometry, counter
// width, controller state encoding and the saturating increment used by
// both the bin store and the pixel counter.
package lbp_pkg;

   localparam int NBIN = 256;
   localparam int CW   = 14;
   localparam int AW   = $clog2(NBIN);

   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [AW-1:0] LAST_BIN = AW'(NBIN - 1);

   localparam logic [1:0] ST_ACC  = 2'd0;
   localparam logic [1:0] ST_DUMP = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Counters stick at full scale instead of wrapping back to zero.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + CW'(1);
   endfunction

endpackage

// File: rtl/lbp_hist_if.sv
// Bundle of the LBP input stream, the histogram readout handshake and the
// status outputs. The slave side is the histogram block.
interface lbp_hist_if;
   import lbp_pkg::*;

   logic          lbp_valid;
   logic [AW-1:0] lbp_data;
   logic [13:0]   lbp_addr;
   logic          finish;
   logic          hist_valid;
   logic          hist_ready;
   logic [AW-1:0] hist_bin;
   logic [CW-1:0] hist_count;
   logic          hist_last;
   logic          hist_done;
   logic [CW-1:0] pix_total;
   logic          drop_err;

   modport slave (
      input  lbp_valid, lbp_data, lbp_addr, finish, hist_ready,
      output hist_valid, hist_bin, hist_count, hist_last, hist_done,
             pix_total, drop_err
   );

   modport master (
      output lbp_valid, lbp_data, lbp_addr, finish, hist_ready,
      input  hist_valid, hist_bin, hist_count, hist_last, hist_done,
             pix_total, drop_err
   );

endinterface

// File: rtl/lbp_bin_ram.sv
// 256 x 14-bit register file holding the histogram bins. One saturating
// increment port and one read port with a separate clear address.
module lbp_bin_ram
   import lbp_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          inc_en_i,
   input  logic [AW-1:0] inc_addr_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [CW-1:0] rd_data_o,
   input  logic          clr_en_i,
   input  logic [AW-1:0] clr_addr_i
);

   logic [CW-1:0] bin_q [NBIN];

   // Read returns the post-increment value when an increment lands on the
   // same bin this cycle, so a snapshot taken now is never one short.
   always_comb begin
      rd_data_o = bin_q[rd_addr_i];
      if (inc_en_i && (inc_addr_i == rd_addr_i)) begin
         rd_data_o = sat_inc(bin_q[rd_addr_i]);
      end
   end

   // Bin update: saturating increment, clear-after-read overrides it.
   // NOTE: the whole array is reset because a reset must leave every bin at
   // zero immediately; this rules out mapping the store onto SRAM macros.
   // NOTE: non-blocking assignment keeps each bin's read-modify-write using
   // the value from before the edge, so back-to-back strobes all count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NBIN; i++) begin
            bin_q[i] <= '0;
         end
      end else begin
         if (inc_en_i) begin
            bin_q[inc_addr_i] <= sat_inc(bin_q[inc_addr_i]);
         end
         if (clr_en_i) begin
            bin_q[clr_addr_i] <= '0;
         end
      end
   end

endmodule

// File: rtl/lbp_hist.sv
// LBP histogram: accumulates codes into 256 bins while in ACC, then on a
// rising edge of finish streams every bin out over a valid/ready port,
// clearing each bin as it is accepted, and pulses hist_done at the end.
module lbp_hist
   import lbp_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   lbp_hist_if.slave bus
);

   logic [1:0]    state_q, state_d;
   logic          finish_q;
   logic          armed_q;
   logic          hist_valid_q, hist_valid_d;
   logic [AW-1:0] hist_bin_q, hist_bin_d;
   logic [CW-1:0] hist_count_q, hist_count_d;
   logic          hist_last_q, hist_last_d;
   logic          hist_done_q, hist_done_d;
   logic [CW-1:0] pix_total_q, pix_total_d;
   logic          drop_err_q, drop_err_d;

   logic          inc_en;
   logic          clr_en;
   logic          xfer;
   logic          finish_rise;
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] rd_data;
   logic          unused_addr;

   // The pixel count follows the strobes, so the address is not needed.
   assign unused_addr = ^bus.lbp_addr;

   // armed_q masks the first cycle after reset: finish_q restarts at zero,
   // and a finish still held high from before reset must not look like a
   // fresh frame-complete edge.
   assign finish_rise = bus.finish & ~finish_q & armed_q;
   assign inc_en      = (state_q == ST_ACC) & bus.lbp_valid;
   assign xfer        = hist_valid_q & bus.hist_ready;

   lbp_bin_ram u_ram (
      .clk        (clk),
      .reset      (reset),
      .inc_en_i   (inc_en),
      .inc_addr_i (bus.lbp_data),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data),
      .clr_en_i   (clr_en),
      .clr_addr_i (hist_bin_q)
   );

   // Controller next state: accumulate, stream bins, one-cycle done.
   // NOTE: every output of this block gets a default first so no path
   // leaves a value unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d      = state_q;
      hist_valid_d = hist_valid_q;
      hist_bin_d   = hist_bin_q;
      hist_count_d = hist_count_q;
      hist_last_d  = hist_last_q;
      hist_done_d  = 1'b0;
      pix_total_d  = pix_total_q;
      drop_err_d   = drop_err_q | (bus.lbp_valid & (state_q != ST_ACC));
      rd_addr      = '0;
      clr_en       = 1'b0;
      case (state_q)
         ST_ACC: begin
            if (inc_en) begin
               pix_total_d = sat_inc(pix_total_q);
            end
            if (finish_rise) begin
               state_d      = ST_DUMP;
               hist_valid_d = 1'b1;
               hist_bin_d   = '0;
               hist_count_d = rd_data;
               hist_last_d  = 1'b0;
            end
         end
         ST_DUMP: begin
            if (xfer) begin
               clr_en = 1'b1;
               if (hist_bin_q == LAST_BIN) begin
                  state_d      = ST_DONE;
                  hist_valid_d = 1'b0;
                  hist_last_d  = 1'b0;
                  hist_done_d  = 1'b1;
                  pix_total_d  = '0;
               end else begin
                  hist_bin_d   = hist_bin_q + AW'(1);
                  rd_addr      = hist_bin_d;
                  hist_count_d = rd_data;
                  hist_last_d  = (hist_bin_d == LAST_BIN);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_ACC;
         end
         default: begin
            state_d = ST_ACC;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_ACC;
         finish_q     <= 1'b0;
         armed_q      <= 1'b0;
         hist_valid_q <= 1'b0;
         hist_bin_q   <= '0;
         hist_count_q <= '0;
         hist_last_q  <= 1'b0;
         hist_done_q  <= 1'b0;
         pix_total_q  <= '0;
         drop_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         finish_q     <= bus.finish;
         armed_q      <= 1'b1;
         hist_valid_q <= hist_valid_d;
         hist_bin_q   <= hist_bin_d;
         hist_count_q <= hist_count_d;
         hist_last_q  <= hist_last_d;
         hist_done_q  <= hist_done_d;
         pix_total_q  <= pix_total_d;
         drop_err_q   <= drop_err_d;
      end
   end

   assign bus.hist_valid = hist_valid_q;
   assign bus.hist_bin   = hist_bin_q;
   assign bus.hist_count = hist_count_q;
   assign bus.hist_last  = hist_last_q;
   assign bus.hist_done  = hist_done_q;
   assign bus.pix_total  = pix_total_q;
   assign bus.drop_err   = drop_err_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Bench for lbp_hist: stimulus pushes the expected 256-word readout into a
// scoreboard when a frame is closed; a monitor pops and compares words as
// the DUT presents them.
module tb_lbp_hist;
   import lbp_pkg::*;

   typedef struct packed {
      logic [7:0]  bin;
      logic [13:0] count;
      logic        last;
   } word_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   lbp_hist_if bus ();

   lbp_hist dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   word_t sb[$];
   word_t mon_e;
   int    exp_bin [256];
   int    exp_pix;
   int    n_checks = 0;
   int    n_fail   = 0;
   logic  last_xfer;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One accepted pixel; the model mirrors the saturating behaviour.
   task automatic pix(input logic [7:0] code, input logic [13:0] addr);
      bus.lbp_valid = 1'b1;
      bus.lbp_data  = code;
      bus.lbp_addr  = addr;
      if (exp_bin[code] < 16383) exp_bin[code]++;
      if (exp_pix < 16383) exp_pix++;
      tick();
      bus.lbp_valid = 1'b0;
   endtask

   task automatic clear_model();
      for (int k = 0; k < 256; k++) exp_bin[k] = 0;
      exp_pix = 0;
   endtask

   // Queue the full readout, raise finish and confirm the first word.
   task automatic start_dump(input bit hold);
      for (int k = 0; k < 256; k++) begin
         sb.push_back('{bin: 8'(k), count: 14'(exp_bin[k]), last: (k == 255)});
      end
      clear_model();
      bus.finish = 1'b1;
      tick();
      check("dump_entry_valid", bus.hist_valid, 1);
      check("dump_entry_bin", bus.hist_bin, 0);
      if (!hold) bus.finish = 1'b0;
   endtask

   // Drive hist_ready from a 4-cycle pattern until hist_done appears.
   task automatic run_dump(input logic [3:0] pat, output int cycles);
      cycles = 0;
      while (bus.hist_done !== 1'b1 && cycles < 3000) begin
         bus.hist_ready = pat[cycles % 4];
         tick();
         cycles++;
      end
      check("dump_done_seen", bus.hist_done, 1);
      check("pix_after_dump", bus.pix_total, 0);
      check("queue_drained", sb.size(), 0);
      tick();
      check("done_one_cycle", bus.hist_done, 0);
   endtask

   // Monitor: compare each presented word with the scoreboard front and
   // require hist_done exactly in the cycle after the last word.
   initial begin
      last_xfer = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            last_xfer = 1'b0;
         end else begin
            if (bus.hist_done || last_xfer) check("hist_done", bus.hist_done, last_xfer);
            last_xfer = 1'b0;
            if (bus.hist_valid) begin
               if (sb.size() == 0) begin
                  check("unexpected_word", bus.hist_valid, 0);
               end else begin
                  mon_e = sb[0];
                  check("word_bin", bus.hist_bin, mon_e.bin);
                  check("word_count", bus.hist_count, mon_e.count);
                  check("word_last", bus.hist_last, mon_e.last);
                  if (bus.hist_ready) begin
                     void'(sb.pop_front());
                     last_xfer = mon_e.last;
                  end
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int vcnt;

      reset          = 1'b0;
      bus.lbp_valid  = 1'b0;
      bus.lbp_data   = '0;
      bus.lbp_addr   = '0;
      bus.finish     = 1'b0;
      bus.hist_ready = 1'b0;
      clear_model();
      #1;
      check("rst_valid", bus.hist_valid, 0);
      check("rst_bin", bus.hist_bin, 0);
      check("rst_count", bus.hist_count, 0);
      check("rst_last", bus.hist_last, 0);
      check("rst_done", bus.hist_done, 0);
      check("rst_pix", bus.pix_total, 0);
      check("rst_drop", bus.drop_err, 0);
      tick();
      tick();
      reset = 1'b1;
      tick();

      // Three strobes of 0x5A, full-rate dump, finish left high afterwards.
      for (int i = 0; i < 3; i++) pix(8'h5A, 14'(i));
      check("pix_three", bus.pix_total, 3);
      start_dump(1'b1);
      run_dump(4'b1111, cyc);
      check("dump_cycles", cyc, 256);
      vcnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.hist_valid) vcnt++;
      end
      check("no_retrigger_level", vcnt, 0);
      bus.finish = 1'b0;
      tick();

      // Full 126x126 frame of code 0xFF.
      for (int r = 0; r < 126; r++) begin
         for (int c = 0; c < 126; c++) pix(8'hFF, {7'(r), 7'(c)});
      end
      check("pix_frame", bus.pix_total, 15876);
      start_dump(1'b0);
      run_dump(4'b1111, cyc);

      // Saturation: 16400 strobes of code 0x01.
      for (int i = 0; i < 16400; i++) pix(8'h01, 14'(i));
      check("pix_saturated", bus.pix_total, 16383);
      start_dump(1'b0);
      run_dump(4'b1111, cyc);

      // Stalled readout with hist_ready pattern 1,0,0,1.
      pix(8'h00, 14'd0);
      pix(8'h00, 14'd1);
      pix(8'h80, 14'd2);
      for (int i = 0; i < 4; i++) pix(8'hFE, 14'(3 + i));
      pix(8'hFF, 14'd7);
      check("pix_mixed", bus.pix_total, 8);
      start_dump(1'b0);
      run_dump(4'b1001, cyc);

      // Strobe during DUMP is dropped and flagged; bin 0x10 keeps 2.
      pix(8'h10, 14'd0);
      pix(8'h10, 14'd1);
      start_dump(1'b0);
      bus.lbp_valid = 1'b1;
      bus.lbp_data  = 8'h10;
      tick();
      bus.lbp_valid = 1'b0;
      check("drop_err_set", bus.drop_err, 1);
      run_dump(4'b1111, cyc);
      check("drop_err_sticky", bus.drop_err, 1);
      pix(8'h33, 14'd0);
      start_dump(1'b0);
      run_dump(4'b1111, cyc);

      // Reset in the middle of a readout, finish held high throughout.
      for (int i = 0; i < 5; i++) pix(8'h64, 14'(i));
      pix(8'h07, 14'd5);
      start_dump(1'b1);
      bus.hist_ready = 1'b1;
      cyc = 0;
      while (bus.hist_bin !== 8'd100 && cyc < 400) begin
         tick();
         cyc++;
      end
      check("reached_bin_100", bus.hist_bin, 100);
      reset = 1'b0;
      #1;
      check("abort_valid", bus.hist_valid, 0);
      check("abort_pix", bus.pix_total, 0);
      check("abort_drop", bus.drop_err, 0);
      sb.delete();
      clear_model();
      tick();
      reset = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.hist_valid || bus.hist_done) vcnt++;
      end
      check("no_dump_after_reset", vcnt, 0);
      bus.finish = 1'b0;
      tick();
      start_dump(1'b0);
      run_dump(4'b1111, cyc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lbp_hist.md
LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port lbp_valid, input, 1, LBP result strobe; one pixel per high cycle.
REQ-004 SHALL have port lbp_data, input, 8, LBP code of current pixel.
REQ-005 SHALL have port lbp_addr, input, 14, pixel address {row,col}; used only for frame-pixel counting.
REQ-006 SHALL have port finish, input, 1, level-high frame-complete from LBP stage.
REQ-007 SHALL have port hist_valid, output, 1, histogram word available.
REQ-008 SHALL have port hist_ready, input, 1, consumer accepts word when high with hist_valid.
REQ-009 SHALL have port hist_bin, output, 8, bin index of current word.
REQ-010 SHALL have port hist_count, output, 14, count of current bin.
REQ-011 SHALL have port hist_last, output, 1, high with bin 255.
REQ-012 SHALL have port hist_done, output, 1, one-cycle pulse after bin 255 accepted.
REQ-013 SHALL have port pix_total, output, 14, pixels accumulated this frame.
REQ-014 SHALL have port drop_err, output, 1, sticky: lbp_valid seen outside ACC.

Function
REQ-015 SHALL hold 256 bins x 14 bits; parameters NBIN=256, CW=14.
REQ-016 SHALL implement states ACC, DUMP, DONE; reset state ACC.
REQ-017 In ACC, each lbp_valid cycle SHALL increment bin[lbp_data] and pix_total by 1, visible the next cycle.
REQ-018 Back-to-back lbp_valid on the same code SHALL count every strobe (no lost read-modify-write).
REQ-019 Bin and pix_total SHALL saturate at 16383; no wrap.
REQ-020 Rising edge of finish (registered finish_d low, finish high) in ACC SHALL move to DUMP next cycle; level-high finish without edge SHALL NOT retrigger.
REQ-021 On DUMP entry: hist_valid=1, hist_bin=0, hist_count=bin[0], all registered.
REQ-022 Word transfers when hist_valid&hist_ready; held stable while hist_ready low.
REQ-023 On transfer of bin k<255: bin[k] cleared, hist_bin=k+1, hist_count=bin[k+1] next cycle; one word per cycle max.
REQ-024 On transfer of bin 255: bin[255] cleared, hist_valid=0, state DONE, pix_total cleared.
REQ-025 DONE SHALL last one cycle with hist_done=1, then ACC.
REQ-026 lbp_valid in DUMP or DONE SHALL be discarded and set drop_err; drop_err cleared only by reset.
REQ-027 finish rising edge during DUMP/DONE SHALL be ignored.

Reset
REQ-028 On reset low, asynchronously: all bins 0, pix_total 0, state ACC, finish_d 0, hist_valid 0, hist_bin 0, hist_count 0, hist_last 0, hist_done 0, drop_err 0.
REQ-029 Reset mid-DUMP SHALL abort readout; no further words or hist_done until a new finish edge.

Structure
REQ-030 NBIN, CW, state encoding (ACC=0, DUMP=1, DONE=2) SHALL live in shared package lbp_pkg.
REQ-031 Bin storage SHALL be a single sub-module lbp_bin_ram (256x14 registers, one increment port, one read/clear port).
REQ-032 Control FSM, edge detect and output registers SHALL reside in lbp_hist.

Verification
REQ-033 Reset, 3 strobes code 0x5A, finish edge, hist_ready=1 -> bin 0x5A count 3, others 0, 256 words in 256 cycles, hist_done 1 cycle after bin 255, pix_total 3 before dump.
REQ-034 Full 126x126 frame of code 0xFF -> bin 255 = 15876, hist_last with it, pix_total 15876.
REQ-035 16400 strobes code 0x01 -> bin 1 = 16383 (saturated), pix_total 16383.
REQ-036 hist_ready toggled 1,0,0,1 during DUMP -> hist_bin/hist_count stable while low, no word skipped or repeated.
REQ-037 lbp_valid code 0x10 during DUMP -> drop_err=1, bin 0x10 unchanged; next frame starts all bins 0.
REQ-038 reset low at bin 100 of DUMP -> hist_valid 0 immediately, all bins 0; finish held high without edge -> no DUMP.
